// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, FSM states and flip-bit indices for the ALU fault-check controller
package alu_ctrl_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MAX = OP_SRA;

    localparam int FLIP_W      = 3;
    localparam int FLIP_ADDER1 = 0;
    localparam int FLIP_ADDER2 = 1;
    localparam int FLIP_SHIFT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_check_op_map.sv
// rtl/alu_check_op_map.sv - maps a primary op and its pass-1 result to the pass-2 check op and expected value
module alu_check_op_map
    import alu_ctrl_pkg::*;
(
    input  logic [4:0]  i_opcode,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [31:0] i_r1,
    output logic [4:0]  o_chk_opcode,
    output logic [31:0] o_chk_a,
    output logic [31:0] o_chk_b,
    output logic [31:0] o_expected
);

    // Add/sub are checked by their inverse; logic ops by commuting; shifts by plain re-execution.
    always_comb begin
        o_chk_opcode = i_opcode;
        o_chk_a      = i_op_a;
        o_chk_b      = i_op_b;
        o_expected   = i_r1;
        case (i_opcode)
            OP_ADD: begin
                o_chk_opcode = OP_SUB;
                o_chk_a      = i_r1;
                o_expected   = i_op_a;
            end
            OP_SUB: begin
                o_chk_opcode = OP_ADD;
                o_chk_a      = i_r1;
                o_expected   = i_op_a;
            end
            OP_AND, OP_OR: begin
                o_chk_a = i_op_b;
                o_chk_b = i_op_a;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_fault_check_ctrl.sv
// rtl/alu_fault_check_ctrl.sv - time-redundant two-pass ALU sequencer with retry and fault counting
module alu_fault_check_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_op_a,
    input  logic [31:0]       i_req_op_b,
    input  logic [4:0]        i_req_opcode,
    input  logic [4:0]        i_req_shamt,
    input  logic [2:0]        i_inj_mask,
    input  logic [1:0]        i_inj_pass,
    output logic [31:0]       o_alu_op_a,
    output logic [31:0]       o_alu_op_b,
    output logic [4:0]        o_alu_opcode,
    output logic [4:0]        o_alu_shamt,
    output logic [2:0]        o_alu_flip,
    input  logic [31:0]       i_alu_result,
    input  logic              i_alu_ne,
    input  logic              i_alu_lt,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_result,
    output logic              o_rsp_ne,
    output logic              o_rsp_lt,
    output logic              o_rsp_fault,
    output logic              o_rsp_illegal,
    output logic [CNT_W-1:0]  o_fault_count
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t            r_state, w_next;
    logic [31:0]       r_op_a, r_op_b, r_r1;
    logic [4:0]        r_opcode, r_shamt;
    logic [2:0]        r_inj_mask;
    logic [1:0]        r_inj_pass;
    logic              r_ne1, r_lt1;
    logic [RW-1:0]     r_retry_cnt;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_ne, r_rsp_lt, r_rsp_fault, r_rsp_illegal;
    logic [CNT_W-1:0]  r_fault_count;

    logic [4:0]        w_chk_opcode;
    logic [31:0]       w_chk_a, w_chk_b, w_expected;
    logic              w_match, w_give_up;

    alu_check_op_map u_map (
        .i_opcode     (r_opcode),
        .i_op_a       (r_op_a),
        .i_op_b       (r_op_b),
        .i_r1         (r_r1),
        .o_chk_opcode (w_chk_opcode),
        .o_chk_a      (w_chk_a),
        .o_chk_b      (w_chk_b),
        .o_expected   (w_expected)
    );

    assign w_match   = (i_alu_result == w_expected);
    assign w_give_up = (r_retry_cnt == RETRY_LIMIT);

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_alu_op_a   = '0;
        o_alu_op_b   = '0;
        o_alu_opcode = '0;
        o_alu_shamt  = '0;
        o_alu_flip   = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) w_next = (i_req_opcode > OP_MAX) ? ST_RESP : ST_PASS1;
            end
            ST_PASS1: begin
                o_alu_op_a   = r_op_a;
                o_alu_op_b   = r_op_b;
                o_alu_opcode = r_opcode;
                o_alu_shamt  = r_shamt;
                o_alu_flip   = r_inj_pass[0] ? r_inj_mask : 3'b000;
                w_next       = ST_PASS2;
            end
            ST_PASS2: begin
                o_alu_op_a   = w_chk_a;
                o_alu_op_b   = w_chk_b;
                o_alu_opcode = w_chk_opcode;
                o_alu_shamt  = r_shamt;
                o_alu_flip   = r_inj_pass[1] ? r_inj_mask : 3'b000;
                w_next       = (w_match || w_give_up) ? ST_RESP : ST_PASS1;
            end
            ST_RESP: begin
                if (i_rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_opcode      <= '0;
            r_shamt       <= '0;
            r_inj_mask    <= '0;
            r_inj_pass    <= '0;
            r_r1          <= '0;
            r_ne1         <= 1'b0;
            r_lt1         <= 1'b0;
            r_retry_cnt   <= '0;
            r_rsp_result  <= '0;
            r_rsp_ne      <= 1'b0;
            r_rsp_lt      <= 1'b0;
            r_rsp_fault   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_fault_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_req_valid) begin
                    r_op_a        <= i_req_op_a;
                    r_op_b        <= i_req_op_b;
                    r_opcode      <= i_req_opcode;
                    r_shamt       <= i_req_shamt;
                    r_inj_mask    <= i_inj_mask;
                    r_inj_pass    <= i_inj_pass;
                    r_retry_cnt   <= '0;
                    r_rsp_result  <= '0;
                    r_rsp_ne      <= 1'b0;
                    r_rsp_lt      <= 1'b0;
                    r_rsp_fault   <= 1'b0;
                    r_rsp_illegal <= (i_req_opcode > OP_MAX);
                end
                ST_PASS1: begin
                    r_r1  <= i_alu_result;
                    r_ne1 <= i_alu_ne;
                    r_lt1 <= i_alu_lt;
                end
                ST_PASS2: begin
                    if (w_match || w_give_up) begin
                        r_rsp_result <= r_r1;
                        r_rsp_ne     <= r_ne1;
                        r_rsp_lt     <= r_lt1;
                        r_rsp_fault  <= !w_match;
                        if (!w_match && (r_fault_count != {CNT_W{1'b1}}))
                            r_fault_count <= r_fault_count + 1'b1;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready   = (r_state == ST_IDLE);
    assign o_rsp_valid   = (r_state == ST_RESP);
    assign o_rsp_result  = r_rsp_result;
    assign o_rsp_ne      = r_rsp_ne;
    assign o_rsp_lt      = r_rsp_lt;
    assign o_rsp_fault   = r_rsp_fault;
    assign o_rsp_illegal = r_rsp_illegal;
    assign o_fault_count = r_fault_count;

endmodule

// File: tb/tb_alu_fault_check_ctrl.sv
// tb/tb_alu_fault_check_ctrl.sv - directed self-checking bench with a fault-injectable ALU model
module tb_alu_fault_check_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_op_a, req_op_b;
    logic [4:0]  req_opcode, req_shamt;
    logic [2:0]  inj_mask;
    logic [1:0]  inj_pass;
    logic [31:0] alu_op_a, alu_op_b, alu_result;
    logic [4:0]  alu_opcode, alu_shamt;
    logic [2:0]  alu_flip;
    logic        alu_ne, alu_lt;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_ne, rsp_lt, rsp_fault, rsp_illegal;
    logic [15:0] fault_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_fault_check_ctrl #(.MAX_RETRY(2), .CNT_W(16)) dut (
        .i_clock       (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op_a    (req_op_a),
        .i_req_op_b    (req_op_b),
        .i_req_opcode  (req_opcode),
        .i_req_shamt   (req_shamt),
        .i_inj_mask    (inj_mask),
        .i_inj_pass    (inj_pass),
        .o_alu_op_a    (alu_op_a),
        .o_alu_op_b    (alu_op_b),
        .o_alu_opcode  (alu_opcode),
        .o_alu_shamt   (alu_shamt),
        .o_alu_flip    (alu_flip),
        .i_alu_result  (alu_result),
        .i_alu_ne      (alu_ne),
        .i_alu_lt      (alu_lt),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_result  (rsp_result),
        .o_rsp_ne      (rsp_ne),
        .o_rsp_lt      (rsp_lt),
        .o_rsp_fault   (rsp_fault),
        .o_rsp_illegal (rsp_illegal),
        .o_fault_count (fault_count)
    );

    // Shared ALU stand-in: adder flips invert result bit 0 / bit 1, shift flip shifts one extra place.
    logic [5:0]  amt;
    logic [31:0] add_flip;
    always_comb begin
        amt      = {1'b0, alu_shamt} + {5'b0, alu_flip[FLIP_SHIFT]};
        add_flip = {30'b0, alu_flip[FLIP_ADDER2], alu_flip[FLIP_ADDER1]};
        alu_ne   = (alu_op_a != alu_op_b);
        alu_lt   = ($signed(alu_op_a) < $signed(alu_op_b));
        case (alu_opcode)
            OP_ADD:  alu_result = (alu_op_a + alu_op_b) ^ add_flip;
            OP_SUB:  alu_result = (alu_op_a - alu_op_b) ^ add_flip;
            OP_AND:  alu_result = alu_op_a & alu_op_b;
            OP_OR:   alu_result = alu_op_a | alu_op_b;
            OP_SLL:  alu_result = (amt > 6'd31) ? 32'h0 : (alu_op_a << amt);
            OP_SRA:  alu_result = $unsigned($signed(alu_op_a) >>> amt);
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is first seen (lat = edges after accept).
    task automatic send(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [2:0] mask, input logic [1:0] pass,
                        output int lat);
        req_opcode = opc; req_op_a = a; req_op_b = b; req_shamt = sh;
        inj_mask = mask; inj_pass = pass; req_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_post_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [2:0] mask,
                          input logic [1:0] pass, input logic [31:0] e_res, input logic e_ne,
                          input logic e_lt, input logic e_fault, input int e_lat, input int e_fc);
        int lat;
        send(opc, a, b, sh, mask, pass, lat);
        check({tag, "_lat"},    lat, e_lat);
        check({tag, "_result"}, rsp_result, e_res);
        check({tag, "_ne"},     {31'b0, rsp_ne}, {31'b0, e_ne});
        check({tag, "_lt"},     {31'b0, rsp_lt}, {31'b0, e_lt});
        check({tag, "_fault"},  {31'b0, rsp_fault}, {31'b0, e_fault});
        check({tag, "_illegal"},{31'b0, rsp_illegal}, 32'd0);
        check({tag, "_fcount"}, {16'b0, fault_count}, e_fc);
        check({tag, "_alu_idle"}, {27'b0, alu_opcode} | alu_op_a | {29'b0, alu_flip}, 32'd0);
        handshake(tag);
    endtask

    initial begin
        int lat;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op_a = '0; req_op_b = '0; req_opcode = '0; req_shamt = '0;
        inj_mask = '0; inj_pass = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_fcount",    {16'b0, fault_count}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_alu_op_a",  alu_op_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //     tag         opc     A             B             sh    mask    pass   result        ne    lt    flt   lat fc
        run_op("add",      OP_ADD, 32'd5,        32'd7,        5'd0, 3'b000, 2'b00, 32'd12,       1'b1, 1'b1, 1'b0, 3, 0);
        run_op("sub_eq",   OP_SUB, 32'd3,        32'd3,        5'd0, 3'b000, 2'b00, 32'd0,        1'b0, 1'b0, 1'b0, 3, 0);
        run_op("sub_neg",  OP_SUB, 32'd2,        32'd9,        5'd0, 3'b000, 2'b00, 32'hFFFFFFF9, 1'b1, 1'b1, 1'b0, 3, 0);
        run_op("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'd1,        5'd0, 3'b000, 2'b00, 32'd0,        1'b1, 1'b1, 1'b0, 3, 0);
        run_op("or",       OP_OR,  32'h0000F00F, 32'h00FF0000, 5'd0, 3'b000, 2'b00, 32'h00FFF00F, 1'b1, 1'b1, 1'b0, 3, 0);
        run_op("sra",      OP_SRA, 32'h80000000, 32'd0,        5'd4, 3'b000, 2'b00, 32'hF8000000, 1'b1, 1'b1, 1'b0, 3, 0);
        run_op("add_flt",  OP_ADD, 32'h10,       32'h01,       5'd0, 3'b001, 2'b01, 32'h10,       1'b1, 1'b0, 1'b1, 7, 1);
        run_op("sub_flt2", OP_SUB, 32'd20,       32'd4,        5'd0, 3'b010, 2'b10, 32'd16,       1'b1, 1'b0, 1'b1, 7, 2);
        run_op("sll_cm",   OP_SLL, 32'd1,        32'd0,        5'd4, 3'b100, 2'b11, 32'h20,       1'b1, 1'b0, 1'b0, 3, 2);

        send(5'd7, 32'h1234, 32'h5678, 5'd3, 3'b111, 2'b11, lat);
        check("ill_lat", lat, 1);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("ill_valid",   {31'b0, rsp_valid}, 32'd1);
            check("ill_flag",    {31'b0, rsp_illegal}, 32'd1);
            check("ill_result",  rsp_result, 32'd0);
            check("ill_fault",   {31'b0, rsp_fault}, 32'd0);
            check("ill_ready",   {31'b0, req_ready}, 32'd0);
            check("ill_alu",     {27'b0, alu_opcode} | alu_op_a | alu_op_b | {29'b0, alu_flip}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        handshake("ill");

        send(OP_ADD, 32'd1, 32'd1, 5'd0, 3'b000, 2'b00, lat);
        check("rst_mid_precount", {16'b0, fault_count}, 32'd2);
        req_valid = 1'b1; req_opcode = OP_ADD; req_op_a = 32'd1; req_op_b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_in_pass2", {30'b0, alu_opcode[1:0]}, {30'b0, OP_SUB[1:0]});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready",  {31'b0, req_ready}, 32'd1);
        check("rst_mid_valid",  {31'b0, rsp_valid}, 32'd0);
        check("rst_mid_fcount", {16'b0, fault_count}, 32'd0);
        check("rst_mid_alu",    {27'b0, alu_opcode} | alu_op_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("and",      OP_AND, 32'h0000F0F0, 32'h0000FF00, 5'd0, 3'b000, 2'b00, 32'h0000F000, 1'b1, 1'b1, 1'b0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
